// File: rtl/div_result_bcd.sv
// Signed quotient / unsigned remainder to BCD via double-dabble, one bit per clock; REM_BCD_EN adds remainder digits.
// Latency 9 clocks from accept to out_valid; in_ready only when idle, result held until out_ready.
module div_result_bcd (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [7:0] quotient,
   input  logic [3:0] remainder,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       q_sign,
   output logic [3:0] q_hund,
   output logic [3:0] q_tens,
   output logic [3:0] q_ones,
   output logic [3:0] r_tens,
   output logic [3:0] r_ones
);

   typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

   state_t      state, state_nxt;
   logic [7:0]  mag;
   logic [2:0]  cnt;
   logic [11:0] qbcd;
   logic [10:0] qbcd_adj;
   logic        accept;

   function automatic logic [3:0] dd_adj(input logic [3:0] d);
      return (d >= 4'd5) ? d + 4'd3 : d;
   endfunction

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_ready && in_valid;

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)      state_nxt = CONV;
         CONV:    if (cnt == 3'd7)   state_nxt = DONE;
         DONE:    if (out_ready)     state_nxt = IDLE;
         default:                    state_nxt = IDLE;
      endcase
   end

   // Hundreds never reaches 5 for an 8-bit magnitude, so only tens/ones need the add-3 step.
   assign qbcd_adj = {qbcd[10:8], dd_adj(qbcd[7:4]), dd_adj(qbcd[3:0])};

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= 3'd0;
         mag    <= 8'd0;
         qbcd   <= 12'd0;
         q_sign <= 1'b0;
      end else begin
         state <= state_nxt;
         if (accept) begin
            q_sign <= quotient[7];
            mag    <= quotient[7] ? (~quotient + 8'd1) : quotient;
            qbcd   <= 12'd0;
            cnt    <= 3'd0;
         end else if (state == CONV) begin
            qbcd <= {qbcd_adj, mag[7]};
            mag  <= {mag[6:0], 1'b0};
            cnt  <= cnt + 3'd1;
         end
      end
   end

   assign q_hund = qbcd[11:8];
   assign q_tens = qbcd[7:4];
   assign q_ones = qbcd[3:0];

`ifdef REM_BCD_EN
   logic [3:0] rem_sh;
   logic [7:0] rbcd;
   logic [6:0] rbcd_adj;

   // Remainder tens is at most 1, so again only the ones nibble is adjusted.
   assign rbcd_adj = {rbcd[6:4], dd_adj(rbcd[3:0])};

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_sh <= 4'd0;
         rbcd   <= 8'd0;
      end else if (accept) begin
         rem_sh <= remainder;
         rbcd   <= 8'd0;
      end else if (state == CONV && !cnt[2]) begin
         rbcd   <= {rbcd_adj, rem_sh[3]};
         rem_sh <= {rem_sh[2:0], 1'b0};
      end
   end

   assign r_tens = rbcd[7:4];
   assign r_ones = rbcd[3:0];
`else
   logic unused_remainder;
   assign unused_remainder = ^remainder;
   assign r_tens = 4'd0;
   assign r_ones = 4'd0;
`endif

endmodule

// File: doc/div_result_bcd.md
DIV_RESULT_BCD -- requirements
Module: div_result_bcd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clk is the sole clock (rising edge) and rst is a synchronous active-high reset.
REQ-002 Port list SHALL be as follows, one line per port:
  clk  input  1  rising-edge clock.
  rst  input  1  synchronous active-high reset.
  in_valid  input  1  quotient/remainder operands present.
  in_ready  output  1  block can accept operands.
  quotient  input  8  signed two's-complement quotient from the divider stage.
  remainder  input  4  unsigned remainder from the divider stage.
  out_valid  output  1  BCD result valid.
  out_ready  input  1  consumer accepts the result.
  q_sign  output  1  1 = quotient negative.
  q_hund  output  4  BCD hundreds of |quotient|.
  q_tens  output  4  BCD tens of |quotient|.
  q_ones  output  4  BCD ones of |quotient|.
  r_tens  output  4  BCD tens of remainder (REQ-017).
  r_ones  output  4  BCD ones of remainder (REQ-017).

Function
REQ-003 FSM states SHALL be IDLE, CONV and DONE, with IDLE as the reset state.
REQ-004 in_ready SHALL be 1 only in IDLE; out_valid SHALL be 1 only in DONE.
REQ-005 On in_valid && in_ready: latch q_sign = quotient[7], latch an 8-bit unsigned magnitude |quotient| (-128 SHALL give 128), latch remainder, clear the BCD accumulators and the counter, and go to CONV.
REQ-006 CONV SHALL run double-dabble, one bit per cycle, MSB first: add 3 to any BCD nibble >= 5, then shift left by one with the next magnitude bit entering q_ones[0].
REQ-007 A 3-bit iteration counter SHALL count 0..7; after the 8th CONV cycle the FSM SHALL go to DONE.
REQ-008 Remainder conversion SHALL run in the same loop during CONV iterations 0..3, MSB first, then hold.
REQ-009 Latency: out_valid SHALL rise exactly 9 clocks after the accepting edge (1 capture + 8 CONV).
REQ-010 In DONE, all result outputs SHALL hold stable until out_valid && out_ready; on that edge the FSM SHALL go to IDLE.
REQ-011 A new operand SHALL NOT be accepted in the same cycle as a result handoff; it SHALL be accepted no earlier than the following cycle.
REQ-012 in_valid in CONV or DONE SHALL be ignored and SHALL NOT corrupt the conversion in progress.
REQ-013 A zero quotient SHALL produce q_sign=0 with all digits 0; quotient -0 cannot occur.
REQ-014 Result outputs SHALL be registered (no combinational path from inputs to outputs); in_ready and out_valid SHALL decode from the state register only.

Reset
REQ-015 When rst=1 at a clock edge, the FSM SHALL enter IDLE, clear the counter, and set q_sign, all digits and out_valid to 0; in_ready SHALL be 1 on the following cycle.
REQ-016 A reset during CONV or DONE SHALL abort the operation; no out_valid SHALL follow for the aborted operand.

Configuration
REQ-017 Macro REM_BCD_EN: when defined, remainder conversion (REQ-008) SHALL be compiled in and r_tens/r_ones SHALL carry its BCD value; when undefined, no remainder logic SHALL exist, r_tens and r_ones SHALL be tied to 0, and the remainder input SHALL be ignored. Quotient behaviour and latency SHALL be identical in both builds.

Verification
REQ-018 quotient=8'sd127, remainder=4'd9, in_valid pulse -> 9 clocks later out_valid=1, sign=0, digits 1/2/7, r=0/9 (0/0 without REM_BCD_EN).
REQ-019 quotient=-128 (8'h80), remainder=15 -> sign=1, digits 1/2/8, r=1/5.
REQ-020 quotient=0, remainder=0 -> sign=0, all digits 0; quotient=-1 -> sign=1, digits 0/0/1.
REQ-021 out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; second in_valid asserted throughout -> accepted only on the cycle after the handoff.
REQ-022 rst asserted at CONV iteration 4 -> next cycle IDLE, outputs 0, no out_valid; a following operand of 42 converts to 0/4/2 with normal 9-cycle latency.
